// File: rtl/aes_inv_cipher_top.sv
// Iterative AES-128 inverse cipher: stored key schedule, one decryption round per clock.
// State bytes are column-major: text[127:120]=s00, [119:112]=s10, ... [7:0]=s33.
module aes_inv_cipher_top #(
   parameter int NR      = 10,
   parameter bit CLR_OUT = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         kld_i,
   input  logic [127:0] key_i,
   output logic         kdone_o,
   input  logic         ld_i,
   input  logic [127:0] text_in_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [127:0] text_out_o
);

   if (NR != 10) begin : g_nr_check
      $error("aes_inv_cipher_top: only NR=10 (AES-128) is supported");
   end

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   typedef enum logic [1:0] {IDLE, KEXP, KRDY, DEC} state_t;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[x];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return INV_SBOX[x];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] n);
      case (n)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Row r of the state rotates right by r byte positions.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [3:0][7:0] m9, mb, md, me;
      logic [7:0] a, x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a     = col[31-8*i -: 8];
         x2    = xtime(a);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a;
         mb[i] = x8 ^ x2 ^ a;
         md[i] = x8 ^ x4 ^ a;
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
      end
      return o;
   endfunction

   state_t       state_q;
   logic [3:0]   kc_q, rc_q;
   logic         kdone_q, busy_q, done_q;
   logic [127:0] rk_q [0:10];
   logic [127:0] st_q, text_out_q;

   logic [127:0] rk_prev, rk_cur, rk_d;
   logic [31:0]  kw_t, kw0, kw1, kw2, kw3;
   logic [127:0] sr, sb, ark, st_d;
   logic         kld_acc, ld_acc, dec_last;

   // kld restarts the schedule anywhere except mid-block; ld yields to kld.
   assign kld_acc  = kld_i && (state_q != DEC);
   assign ld_acc   = ld_i && !kld_i && (state_q == KRDY);
   assign dec_last = (state_q == DEC) && (rc_q == 4'd0);

   always_comb begin
      rk_prev = rk_q[0];
      rk_cur  = rk_q[0];
      for (int i = 1; i <= 10; i++) begin
         if (kc_q == 4'(i)) rk_prev = rk_q[i-1];
         if (rc_q == 4'(i)) rk_cur  = rk_q[i];
      end
   end

   assign kw_t = {sbox(rk_prev[23:16]), sbox(rk_prev[15:8]), sbox(rk_prev[7:0]),
                  sbox(rk_prev[31:24])} ^ {rcon(kc_q), 24'h0};
   assign kw0  = rk_prev[127:96] ^ kw_t;
   assign kw1  = rk_prev[95:64]  ^ kw0;
   assign kw2  = rk_prev[63:32]  ^ kw1;
   assign kw3  = rk_prev[31:0]   ^ kw2;
   assign rk_d = {kw0, kw1, kw2, kw3};

   assign sr = inv_shift_rows(st_q);
   for (genvar b = 0; b < 16; b++) begin : g_isbox
      assign sb[127-8*b -: 8] = inv_sbox(sr[127-8*b -: 8]);
   end
   assign ark  = sb ^ rk_cur;
   assign st_d = inv_mix_columns(ark);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         kc_q    <= 4'd0;
         rc_q    <= 4'd0;
         kdone_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (kld_acc) begin
            state_q <= KEXP;
            kc_q    <= 4'd1;
            kdone_q <= 1'b0;
         end else begin
            case (state_q)
               KEXP: begin
                  kc_q <= kc_q + 4'd1;
                  if (kc_q == 4'd10) begin
                     state_q <= KRDY;
                     kdone_q <= 1'b1;
                  end
               end
               KRDY: begin
                  if (ld_i) begin
                     state_q <= DEC;
                     rc_q    <= 4'd9;
                     busy_q  <= 1'b1;
                  end
               end
               DEC: begin
                  if (rc_q == 4'd0) begin
                     state_q <= KRDY;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     rc_q <= rc_q - 4'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (kld_acc) begin
         rk_q[0] <= key_i;
      end else if (state_q == KEXP) begin
         for (int i = 1; i <= 10; i++) begin
            if (kc_q == 4'(i)) rk_q[i] <= rk_d;
         end
      end
      if (ld_acc) begin
         st_q <= text_in_i ^ rk_q[10];
      end else if ((state_q == DEC) && (rc_q != 4'd0)) begin
         st_q <= st_d;
      end
   end

   always_ff @(posedge clk) begin
      if (CLR_OUT && !rst) begin
         text_out_q <= '0;
      end else if (rst && dec_last) begin
         text_out_q <= ark;
      end
   end

   assign kdone_o    = kdone_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign text_out_o = text_out_q;

endmodule

// File: tb/tb_aes_inv_cipher_top.sv
// Bench for aes_inv_cipher_top: a byte-level AES-128 model (S-box derived from GF(2^8))
// produces every expected plaintext; a per-cycle monitor checks done/busy/text_out.
module tb_aes_inv_cipher_top;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

   logic         clk, rst, kld, ld;
   logic [127:0] key_r, text_r;
   logic         kdone, busy, done;
   logic [127:0] text_out;

   aes_inv_cipher_top dut (
      .clk       (clk),
      .rst       (rst),
      .kld_i     (kld),
      .key_i     (key_r),
      .kdone_o   (kdone),
      .ld_i      (ld),
      .text_in_i (text_r),
      .busy_o    (busy),
      .done_o    (done),
      .text_out_o(text_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int           due;
      logic [127:0] pt;
   } exp_t;
   typedef logic [0:10][127:0] ks_t;

   exp_t         q[$];
   int           ecnt = 0;
   int           total = 0;
   int           bad = 0;
   bit           mon_en = 1'b0;
   logic [127:0] exp_out = '0;
   logic [7:0]   sb [256];
   logic [7:0]   isb [256];

   always @(posedge clk) ecnt <= ecnt + 1;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, ecnt);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = y >> 1;
      end
      return p;
   endfunction

   task automatic build_tables();
      logic [7:0] inv, b;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sb[x]  = b;
         isb[b] = 8'(x);
      end
   endtask

   function automatic ks_t m_expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      ks_t         ks;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return ks;
   endfunction

   function automatic logic [127:0] m_sub(input logic [127:0] v, input bit inv);
      logic [127:0] o;
      for (int k = 0; k < 16; k++)
         o[127-8*k -: 8] = inv ? isb[v[127-8*k -: 8]] : sb[v[127-8*k -: 8]];
      return o;
   endfunction

   function automatic logic [127:0] m_shift(input logic [127:0] v, input int dir);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = v[127-8*(4*((c+dir*r+4)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] m_mix(input logic [127:0] v, input logic [31:0] cf);
      logic [127:0] o;
      logic [7:0]   acc;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(cf[31-8*((j-r+4)%4) -: 8], v[127-8*(4*c+j) -: 8]);
            o[127-8*(4*c+r) -: 8] = acc;
         end
      return o;
   endfunction

   function automatic logic [127:0] m_encrypt(input logic [127:0] key, input logic [127:0] pt);
      ks_t ks;
      logic [127:0] v;
      ks = m_expand(key);
      v  = pt ^ ks[0];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         v = m_shift(m_sub(v, 1'b0), 1);
         if (rnd < 10) v = m_mix(v, 32'h02030101);
         v = v ^ ks[rnd];
      end
      return v;
   endfunction

   function automatic logic [127:0] m_decrypt(input logic [127:0] key, input logic [127:0] ct);
      ks_t ks;
      logic [127:0] v;
      ks = m_expand(key);
      v  = ct ^ ks[10];
      for (int rnd = 9; rnd >= 0; rnd--) begin
         v = m_sub(m_shift(v, -1), 1'b1) ^ ks[rnd];
         if (rnd > 0) v = m_mix(v, 32'h0e0b0d09);
      end
      return v;
   endfunction

   // ---------------- per-cycle monitor ----------------
   always @(negedge clk) begin
      bit hd, bexp;
      if (mon_en) begin
         hd   = (q.size() > 0) && (q[0].due == ecnt);
         bexp = (q.size() > 0) && !hd && (ecnt >= q[0].due - 10);
         check("done", 128'(done), 128'(hd));
         check("busy", 128'(busy), 128'(bexp));
         if (hd) begin
            exp_out = q[0].pt;
            void'(q.pop_front());
         end
         check("text_out", text_out, exp_out);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_kdone();
      int n = 0;
      while (kdone !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("kdone_rise", 128'(kdone), 128'd1);
   endtask

   task automatic load_key(input logic [127:0] k);
      @(negedge clk);
      key_r = k;
      kld   = 1'b1;
      @(negedge clk);
      kld = 1'b0;
      check("kdone_low_after_kld", 128'(kdone), 128'd0);
      wait_kdone();
   endtask

   task automatic dec(input logic [127:0] ct, input logic [127:0] pt, input bit acc);
      @(negedge clk);
      text_r = ct;
      ld     = 1'b1;
      if (acc) q.push_back('{ecnt + 11, pt});
      @(negedge clk);
      ld = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("block_timeout", 128'(q.size()), 128'd0);
      q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] k, p, c;
      rst = 1'b0; kld = 1'b0; ld = 1'b0; key_r = '0; text_r = '0;
      build_tables();
      check("model_sbox", {sb[0], sb[8'h53], isb[0]}, 24'h63ed52);
      check("model_enc_t1", m_encrypt(K1, P1), C1);
      check("model_enc_t2", m_encrypt(K2, P2), C2);
      check("model_dec_t1", m_decrypt(K1, C1), P1);

      repeat (3) @(negedge clk);
      check("rst_kdone", 128'(kdone), 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_done", 128'(done), 128'd0);
      check("rst_text_out", text_out, 128'd0);
      rst    = 1'b1;
      mon_en = 1'b1;

      // ld with no key loaded
      dec(C1, '0, 1'b0);
      repeat (12) @(negedge clk);

      // T1, T2 known vectors
      load_key(K1);
      dec(C1, P1, 1'b1);
      wait_idle();
      load_key(K2);
      dec(C2, P2, 1'b1);
      wait_idle();

      // T3: ld five cycles after kld, before kdone
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      key_r = k;
      kld   = 1'b1;
      @(negedge clk);
      kld = 1'b0;
      repeat (3) @(negedge clk);
      dec(m_encrypt(k, p), '0, 1'b0);
      check("t3_kdone_still_low", 128'(kdone), 128'd0);
      wait_kdone();
      dec(m_encrypt(k, p), p, 1'b1);
      wait_idle();

      // T4: back-to-back, second ld in the done cycle
      load_key(K1);
      dec(C1, P1, 1'b1);
      repeat (9) @(negedge clk);
      dec(128'h0, m_decrypt(K1, 128'h0), 1'b1);
      wait_idle();

      // kld and ld together: key reload wins
      @(negedge clk);
      key_r = K2; kld = 1'b1; text_r = C1; ld = 1'b1;
      @(negedge clk);
      kld = 1'b0; ld = 1'b0;
      check("kld_over_ld_kdone", 128'(kdone), 128'd0);
      wait_kdone();
      dec(C2, P2, 1'b1);
      wait_idle();

      // T5: kld mid-block ignored, then reset mid-block
      load_key(K1);
      dec(C1, P1, 1'b1);
      repeat (3) @(negedge clk);
      key_r = K2;
      kld   = 1'b1;
      @(negedge clk);
      kld = 1'b0;
      check("t5_kdone_held", 128'(kdone), 128'd1);
      wait_idle();
      dec(C1, P1, 1'b1);
      wait_idle();
      dec(C1, P1, 1'b1);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      q.delete();
      exp_out = '0;
      @(negedge clk);
      check("t5_rst_busy", 128'(busy), 128'd0);
      check("t5_rst_done", 128'(done), 128'd0);
      check("t5_rst_text_out", text_out, 128'd0);
      check("t5_rst_kdone", 128'(kdone), 128'd0);
      rst = 1'b1;
      dec(C1, '0, 1'b0);
      repeat (12) @(negedge clk);

      // T6: random key/plaintext loopback through the encryption model
      for (int i = 0; i < 1000; i++) begin
         k = {$urandom(), $urandom(), $urandom(), $urandom()};
         p = {$urandom(), $urandom(), $urandom(), $urandom()};
         c = m_encrypt(k, p);
         load_key(k);
         dec(c, p, 1'b1);
         wait_idle();
      end

      repeat (2) @(negedge clk);
      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
